// File: rtl/button_if.sv
// Button bundle between the board pins and the conditioner.
// The slave side is the conditioner, the master side is the board or game logic.
interface button_if #(
    parameter int N_BTN = 4
) ();
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] dpb;
    logic [N_BTN-1:0] scen;
    logic [N_BTN-1:0] mcen;
    logic             scen_any;

    modport master (
        output btn_raw,
        input  dpb,
        input  scen,
        input  mcen,
        input  scen_any
    );

    modport slave (
        input  btn_raw,
        output dpb,
        output scen,
        output mcen,
        output scen_any
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-button 2-FF synchronizer and debounce FSM.
// Produces a debounced level, a press pulse and an auto-repeat pulse train.
module button_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 15_000_000
) (
    input logic      clk,
    input logic      reset,
    button_if.slave  bus
);
    localparam int CLOG = $clog2(DEBOUNCE_CYCLES);
    localparam int CW   = (CLOG > 0) ? CLOG : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD)
                        ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD);

    typedef enum logic [1:0] {
        IDLE,
        PQUAL,
        HELD,
        RQUAL
    } state_e;

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;
    logic [N_BTN-1:0] accept_d;
    logic [N_BTN-1:0] dpb;
    logic [N_BTN-1:0] scen;
    logic [N_BTN-1:0] mcen;
    logic             scen_any_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            scen_any_q <= 1'b0;
        end else begin
            sync1_q    <= bus.btn_raw;
            sync2_q    <= sync1_q;
            scen_any_q <= |accept_d;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        state_e        state_q;
        logic [CW-1:0] cnt_q;
        logic [RW-1:0] rpt_q;
        logic [RW-1:0] rpt_inc;
        logic [RW-1:0] rpt_tgt;
        logic          rep_q;
        logic          dpb_q;
        logic          scen_q;
        logic          mcen_q;
        logic          s;

        assign s        = sync2_q[i];
        assign rpt_inc  = (rpt_q == '1) ? rpt_q : rpt_q + 1'b1;
        assign rpt_tgt  = rep_q ? R_PERIOD : R_DELAY;
        assign accept_d[i] = (state_q == PQUAL) && s
                          && (cnt_q == CNT_LAST);

        // rep_q marks that the long first-repeat delay has elapsed
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                rpt_q   <= '0;
                rep_q   <= 1'b0;
                dpb_q   <= 1'b0;
                scen_q  <= 1'b0;
                mcen_q  <= 1'b0;
            end else begin
                scen_q <= accept_d[i];
                mcen_q <= 1'b0;
                unique case (state_q)
                    IDLE: begin
                        if (s) begin
                            state_q <= PQUAL;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                    PQUAL: begin
                        if (!s) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else if (accept_d[i]) begin
                            state_q <= HELD;
                            cnt_q   <= '0;
                            rpt_q   <= '0;
                            rep_q   <= 1'b0;
                            dpb_q   <= 1'b1;
                            mcen_q  <= 1'b1;
                        end else if (cnt_q != '1) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!s) begin
                            state_q <= RQUAL;
                            cnt_q   <= CNT_ONE;
                            rpt_q   <= '0;
                        end else if (rpt_inc == rpt_tgt) begin
                            rpt_q  <= '0;
                            rep_q  <= 1'b1;
                            mcen_q <= 1'b1;
                        end else begin
                            rpt_q <= rpt_inc;
                        end
                    end
                    RQUAL: begin
                        if (s) begin
                            state_q <= HELD;
                            cnt_q   <= '0;
                            rpt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            dpb_q   <= 1'b0;
                        end else if (cnt_q != '1) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end

        assign dpb[i]  = dpb_q;
        assign scen[i] = scen_q;
        assign mcen[i] = mcen_q;
    end

    assign bus.dpb      = dpb;
    assign bus.scen     = scen;
    assign bus.mcen     = mcen;
    assign bus.scen_any = scen_any_q;
endmodule
